spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
//  SPI mode-0 responder: the target end of the link driven by our SPI controller. Emulates the accelerometer's
//  byte-register map for system sim and loopback bring-up. Decodes instruction 0x0A (write) / 0x0B (read),
//  then an address byte, then data bytes. Local logic loads/reads the same register file via a side port.
// PARAMETERS
//  ADDR_W   7      register address width; SPI address byte masked to ADDR_W LSBs
//  DEVID    8'hAD  read-only value at address 0; SPI/local writes to address 0 are dropped
// PORTS
//  CLK        in   1       system clock; sole clock domain
//  RST        in   1       synchronous, active-high reset
//  SCLK       in   1       SPI clock from controller (async to CLK)
//  CS         in   1       chip select, active low (async)
//  MOSI       in   1       serial data in, MSB first
//  MISO       out  1       serial data out, MSB first
//  MISO_OE    out  1       high while a read data phase is active
//  LOC_WE     in   1       local register write strobe
//  LOC_ADDR   in   ADDR_W  local read/write address
//  LOC_WDATA  in   8       local write data
//  LOC_RDATA  out  8       register[LOC_ADDR], registered, 1-cycle latency
//  WR_STROBE  out  1       1-cycle pulse when an SPI data byte commits
//  WR_ADDR    out  ADDR_W  address of committed byte (valid with WR_STROBE)
//  BUSY       out  1       synchronised ~CS
// BEHAVIOUR
//  - Reset: all registers 0 (addr 0 reads DEVID), MISO=0, MISO_OE=0, LOC_RDATA=0, WR_STROBE=0, WR_ADDR=0,
//    BUSY=0, FSM=IDLE, bit counter=7. RST mid-transfer aborts it; no commit, remainder ignored until CS high.
//  - SCLK/CS/MOSI pass 2-FF synchronisers; edges from 3rd flop. SCLK high/low phases >= 8 CLK cycles each.
//  - MOSI sampled on detected SCLK rise; MISO updated on detected SCLK fall. Bit counter 7..0 per byte.
//  - FSM: IDLE -(CS fall)-> INSTR -(8 bits)-> ADDR if 0x0A/0x0B else IGNORE; ADDR -(8 bits)-> WDATA or RDATA.
//    IGNORE holds until CS high. Any state -> IDLE within 3 CLK of synced CS high.
//  - WDATA: on 8th rising edge commit byte to reg[addr]; WR_STROBE pulse next CLK; then advance address.
//  - RDATA: at the SCLK fall after last address bit, load reg[addr] into shifter, drive MSB, MISO_OE=1;
//    each later fall shifts next bit; after bit 0 falls reload with next address's byte.
//  - CS high mid-byte: partial byte discarded, no commit, MISO_OE=0, MISO=0 in same cycle as IDLE entry.
//  - Address advance wraps 2^ADDR_W-1 -> 0.
//  - Same-cycle SPI commit and LOC_WE to the same address: SPI wins; local write lost. Different addresses: both.
//  - LOC_RDATA reflects writes committed in the prior cycle (read-after-write = 1 cycle).
//  - SCLK edges while CS high are ignored.
// CONFIGURATION
//  SPI_PERIPH_AUTOINC_EN defined: burst bytes auto-increment the address (wrapping as above).
//  Not defined: address fixed after ADDR phase; burst writes overwrite one register, burst reads repeat it.
// STRUCTURE
//  spi_pkg: opcode constants (OP_WRITE=8'h0A, OP_READ=8'h0B), FSM state encoding
//  (IDLE, INSTR, ADDR, WDATA, RDATA, IGNORE), minimum SCLK half-period constant (8).
//  One sub-module: spi_sync_edge (2-FF sync + edge-detect flop, outputs level, rise, fall); 3 instances.
// TESTING (SCLK half-period 16 CLK unless noted)
//  1 Write 0x0A,0x20,0x5A -> WR_STROBE once, WR_ADDR=0x20; LOC_ADDR=0x20 gives LOC_RDATA=0x5A next cycle.
//  2 LOC write 0x3C@0x21; SPI 0x0B,0x21 + 8 clocks -> MISO 0,0,1,1,1,1,0,0; MISO_OE high only that byte.
//  3 Burst write 0x0A,0x7F,0x11,0x22 -> reg[0x7F]=0x11, reg[0x00]=DEVID unchanged (AUTOINC_EN);
//    without macro reg[0x7F]=0x22.
//  4 Read 0x0B,0x00 -> MISO=0xAD; CS raised after 4 data bits -> MISO_OE=0, FSM IDLE, no WR_STROBE.
//  5 Instr 0x0C,0x20,0xFF -> IGNORE, no commit, MISO_OE stays 0; reg[0x20] unchanged.
//  6 RST mid address byte of write -> outputs at reset values; next full write 0x0A,0x10,0x99 commits cleanly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI mode-0 register-map responder.
package spi_pkg;

  localparam logic [7:0] OP_WRITE = 8'h0A;
  localparam logic [7:0] OP_READ  = 8'h0B;

  // Shortest legal SCLK high/low phase, in CLK cycles.
  localparam int SCLK_HALF_MIN = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INSTR  = 3'd1,
    ADDR   = 3'd2,
    WDATA  = 3'd3,
    RDATA  = 3'd4,
    IGNORE = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-flop synchroniser plus a third flop for edge detection; LEVEL is the synchronised input.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  logic [2:0] sr;

  always_ff @(posedge CLK) begin
    if (RST) sr <= {3{RST_VAL}};
    else     sr <= {sr[1:0], D};
  end

  assign LEVEL = sr[1];
  assign RISE  = sr[1] & ~sr[2];
  assign FALL  = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder emulating a byte-register map (0x0A write / 0x0B read, address, data bytes).
// Define SPI_PERIPH_AUTOINC_EN to make burst bytes auto-increment the register address.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int         ADDR_W = 7,
  parameter logic [7:0] DEVID  = 8'hAD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic              LOC_WE,
  input  logic [ADDR_W-1:0] LOC_ADDR,
  input  logic [7:0]        LOC_WDATA,
  output logic [7:0]        LOC_RDATA,
  output logic              WR_STROBE,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              BUSY,
  output spi_state_e        DBG_STATE
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef SPI_PERIPH_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .CLK(CLK), .RST(RST), .D(SCLK), .LEVEL(sclk_lvl), .RISE(sclk_rise), .FALL(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .CLK(CLK), .RST(RST), .D(CS), .LEVEL(cs_lvl), .RISE(cs_rise), .FALL(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .CLK(CLK), .RST(RST), .D(MOSI), .LEVEL(mosi_lvl), .RISE(mosi_rise), .FALL(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, cs_rise, mosi_rise, mosi_fall};

  logic [7:0]        regs [DEPTH];
  spi_state_e        state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_in;
  logic [7:0]        tx_sh;
  logic [ADDR_W-1:0] addr;
  logic              rd_op;
  logic [3:0]        settle_cnt;

  function automatic logic [7:0] rd_reg(input logic [ADDR_W-1:0] a);
    return (a == '0) ? DEVID : regs[a];
  endfunction

  logic [7:0]        in_byte;
  logic [7:0]        rd_byte;
  logic              byte_done;
  logic              spi_commit;
  logic              settled;
  logic [ADDR_W-1:0] addr_step;

  assign in_byte    = {shift_in[6:0], mosi_lvl};
  assign rd_byte    = rd_reg(addr);
  assign byte_done  = sclk_rise && (bit_cnt == 3'd0);
  assign spi_commit = (state == WDATA) && !cs_lvl && byte_done;
  // A CS fall seen while the synchronisers refill after reset belongs to an aborted transfer.
  assign settled    = (settle_cnt == 4'(SCLK_HALF_MIN));
  assign addr_step  = AUTOINC ? addr + ADDR_W'(1) : addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= 3'd7;
      shift_in   <= '0;
      tx_sh      <= '0;
      addr       <= '0;
      rd_op      <= 1'b0;
      settle_cnt <= '0;
      MISO       <= 1'b0;
      MISO_OE    <= 1'b0;
      WR_STROBE  <= 1'b0;
      WR_ADDR    <= '0;
    end else begin
      WR_STROBE <= spi_commit;
      if (spi_commit) WR_ADDR <= addr;
      if (!settled) settle_cnt <= settle_cnt + 4'd1;

      if (state != IDLE && cs_lvl) begin
        state   <= IDLE;
        bit_cnt <= 3'd7;
        MISO    <= 1'b0;
        MISO_OE <= 1'b0;
      end else begin
        if (sclk_rise && state != IDLE) begin
          shift_in <= in_byte;
          bit_cnt  <= bit_cnt - 3'd1;
        end
        case (state)
          IDLE: begin
            if (cs_fall && settled) begin
              state   <= INSTR;
              bit_cnt <= 3'd7;
            end
          end
          INSTR: begin
            if (byte_done) begin
              rd_op <= (in_byte == OP_READ);
              state <= (in_byte == OP_WRITE || in_byte == OP_READ) ? ADDR : IGNORE;
            end
          end
          ADDR: begin
            if (byte_done) begin
              addr  <= in_byte[ADDR_W-1:0];
              state <= rd_op ? RDATA : WDATA;
            end
          end
          WDATA: begin
            if (byte_done) addr <= addr_step;
          end
          RDATA: begin
            // bit_cnt sits at 7 on the fall that precedes each byte's first rise.
            if (sclk_fall) begin
              if (bit_cnt == 3'd7) begin
                MISO    <= rd_byte[7];
                tx_sh   <= {rd_byte[6:0], 1'b0};
                MISO_OE <= 1'b1;
                addr    <= addr_step;
              end else begin
                MISO  <= tx_sh[7];
                tx_sh <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // SPI write is applied last so it wins a same-address collision with LOC_WE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (LOC_WE && LOC_ADDR != '0) regs[LOC_ADDR] <= LOC_WDATA;
      if (spi_commit && addr != '0) regs[addr] <= in_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) LOC_RDATA <= '0;
    else     LOC_RDATA <= rd_reg(LOC_ADDR);
  end

  assign BUSY      = ~cs_lvl;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: SPI driver tasks, write/read scoreboards, final report.
module tb_spi_peripheral;
  import spi_pkg::*;

  localparam int ADDR_W = 7;
  localparam int HALF   = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              SCLK, CS, MOSI;
  logic              MISO, MISO_OE;
  logic              LOC_WE;
  logic [ADDR_W-1:0] LOC_ADDR;
  logic [7:0]        LOC_WDATA, LOC_RDATA;
  logic              WR_STROBE;
  logic [ADDR_W-1:0] WR_ADDR;
  logic              BUSY;
  spi_state_e        DBG_STATE;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [7:0]        rd_q[$];

  spi_peripheral #(.ADDR_W(ADDR_W), .DEVID(8'hAD)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
    .LOC_WE(LOC_WE), .LOC_ADDR(LOC_ADDR), .LOC_WDATA(LOC_WDATA), .LOC_RDATA(LOC_RDATA),
    .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic half_period();
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      half_period();
      SCLK = 1'b1;
      half_period();
      SCLK = 1'b0;
    end
  endtask

  task automatic cs_start();
    CS = 1'b0;
    half_period();
  endtask

  task automatic cs_stop();
    half_period();
    CS = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  task automatic loc_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge CLK);
    LOC_WE = 1'b1; LOC_ADDR = a; LOC_WDATA = d;
    @(negedge CLK);
    LOC_WE = 1'b0;
  endtask

  task automatic loc_read(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    @(negedge CLK);
    LOC_ADDR = a;
    @(negedge CLK);
    check(name, 32'(LOC_RDATA), 32'(exp));
  endtask

  // Scoreboard monitors: committed write addresses and read bytes on MISO
  always @(negedge CLK) begin
    if (!RST && WR_STROBE) begin
      if (exp_q.size() == 0) check("unexpected_wr_strobe", 32'(WR_ADDR), 32'hFFFF_FFFF);
      else check("wr_addr", 32'(WR_ADDR), 32'(exp_q.pop_front()));
    end
  end

  int         rx_n = 0;
  logic [7:0] rx_sh = '0;
  always @(posedge SCLK or posedge CS) begin
    if (CS) begin
      rx_n = 0;
    end else if (MISO_OE) begin
      rx_sh = {rx_sh[6:0], MISO};
      rx_n++;
      if (rx_n == 8) begin
        rx_n = 0;
        if (rd_q.size() == 0) check("unexpected_read_byte", 32'(rx_sh), 32'hFFFF_FFFF);
        else check("miso_byte", 32'(rx_sh), 32'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    RST = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    LOC_WE = 1'b0; LOC_ADDR = '0; LOC_WDATA = '0;
    repeat (4) @(negedge CLK);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_miso_oe", 32'(MISO_OE), 32'd0);
    check("rst_loc_rdata", 32'(LOC_RDATA), 32'd0);
    check("rst_wr_strobe", 32'(WR_STROBE), 32'd0);
    check("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_state", 32'(DBG_STATE), 32'(IDLE));
    RST = 1'b0;
    repeat (12) @(negedge CLK);

    // 1: single write
    loc_read("devid", 7'h00, 8'hAD);
    exp_q.push_back(7'h20);
    cs_start();
    check("busy_active", 32'(BUSY), 32'd1);
    spi_bits(8'h0A, 8); spi_bits(8'h20, 8); spi_bits(8'h5A, 8);
    cs_stop();
    check("busy_idle", 32'(BUSY), 32'd0);
    loc_read("t1_reg20", 7'h20, 8'h5A);

    // 2: local write, SPI read
    loc_write(7'h21, 8'h3C);
    cs_start();
    spi_bits(8'h0B, 8);
    check("t2_oe_before_data", 32'(MISO_OE), 32'd0);
    rd_q.push_back(8'h3C);
    spi_bits(8'h21, 8);
    spi_bits(8'h00, 8);
    check("t2_oe_in_data", 32'(MISO_OE), 32'd1);
    cs_stop();
    check("t2_oe_after_cs", 32'(MISO_OE), 32'd0);

    // 3: burst write across the top address, then burst read back
    exp_q.push_back(7'h7F);
`ifdef SPI_PERIPH_AUTOINC_EN
    exp_q.push_back(7'h00);
`else
    exp_q.push_back(7'h7F);
`endif
    cs_start();
    spi_bits(8'h0A, 8); spi_bits(8'h7F, 8); spi_bits(8'h11, 8); spi_bits(8'h22, 8);
    cs_stop();
`ifdef SPI_PERIPH_AUTOINC_EN
    loc_read("t3_reg7f", 7'h7F, 8'h11);
    rd_q.push_back(8'h11); rd_q.push_back(8'hAD);
`else
    loc_read("t3_reg7f", 7'h7F, 8'h22);
    rd_q.push_back(8'h22); rd_q.push_back(8'h22);
`endif
    loc_read("t3_reg00", 7'h00, 8'hAD);
    cs_start();
    spi_bits(8'h0B, 8); spi_bits(8'h7F, 8); spi_bits(8'h00, 8); spi_bits(8'h00, 8);
    cs_stop();

    // 4: DEVID read, then a read aborted after four data bits
    rd_q.push_back(8'hAD);
    cs_start();
    spi_bits(8'h0B, 8); spi_bits(8'h00, 8); spi_bits(8'h00, 8);
    cs_stop();
    cs_start();
    spi_bits(8'h0B, 8); spi_bits(8'h00, 8); spi_bits(8'h00, 4);
    cs_stop();
    check("t4_oe_abort", 32'(MISO_OE), 32'd0);
    check("t4_miso_abort", 32'(MISO), 32'd0);
    check("t4_state_abort", 32'(DBG_STATE), 32'(IDLE));

    // 5: unknown instruction is ignored
    cs_start();
    spi_bits(8'h0C, 8);
    repeat (8) @(negedge CLK);
    check("t5_state_ignore", 32'(DBG_STATE), 32'(IGNORE));
    spi_bits(8'h20, 8); spi_bits(8'hFF, 8);
    check("t5_oe", 32'(MISO_OE), 32'd0);
    cs_stop();
    loc_read("t5_reg20", 7'h20, 8'h5A);

    // 6: reset in the middle of a write's address byte
    cs_start();
    spi_bits(8'h0A, 8); spi_bits(8'h10, 3);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("t6_rst_state", 32'(DBG_STATE), 32'(IDLE));
    check("t6_rst_oe", 32'(MISO_OE), 32'd0);
    check("t6_rst_strobe", 32'(WR_STROBE), 32'd0);
    check("t6_rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    spi_bits(8'h10, 5); spi_bits(8'h77, 8);
    check("t6_state_after_rst", 32'(DBG_STATE), 32'(IDLE));
    cs_stop();
    loc_read("t6_reg20_cleared", 7'h20, 8'h00);
    exp_q.push_back(7'h10);
    cs_start();
    spi_bits(8'h0A, 8); spi_bits(8'h10, 8); spi_bits(8'h99, 8);
    cs_stop();
    loc_read("t6_reg10", 7'h10, 8'h99);

    // Report
    repeat (20) @(negedge CLK);
    check("wr_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
